// File: rtl/lift_pkg.sv
// Shared definitions for the lift request path: default sizing, the floor
// index type and the door sequencing states.
package lift_pkg;

  localparam int LIFT_NUM_FLOORS  = 8;
  localparam int LIFT_FLOOR_W     = $clog2(LIFT_NUM_FLOORS);
  localparam int LIFT_DOOR_CYCLES = 4;

  typedef logic [LIFT_FLOOR_W-1:0] floor_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DOOR  = 2'd1,
    ST_CLOSE = 2'd2
  } door_state_t;

endpackage

// File: rtl/floor_request_queue_req_extremes.sv
// Highest / lowest pending floor over the request vector. With no pending
// requests both outputs fall back to the current floor so the lift holds.
module req_extremes
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS = LIFT_NUM_FLOORS,
  parameter int FLOOR_W    = LIFT_FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] requests,
  input  logic [FLOOR_W-1:0]    current_floor,
  output logic [FLOOR_W-1:0]    max_request,
  output logic [FLOOR_W-1:0]    min_request
);

  // upward scan: the last set bit seen is the highest pending floor
  always_comb begin
    max_request = current_floor;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (requests[i]) max_request = FLOOR_W'(i);
    end
  end

  // downward scan: the last set bit seen is the lowest pending floor
  always_comb begin
    min_request = current_floor;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (requests[i]) min_request = FLOOR_W'(i);
    end
  end

endmodule

// File: rtl/floor_request_queue.sv
// Floor request queue: latches button presses, derives request extremes,
// runs the door cycle on arrival at a requested floor and gates lift_en.
// Optional feature macro: FLR_REQ_DOOR_REOPEN_EN (a press on the current
// floor during the door cycle reopens / extends the door).
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_RUN   | lift may move; waiting to arrive on a requested floor
// ST_DOOR  | door_open high, counting down the open time
// ST_CLOSE | one cycle with the door closed before the lift may move
module floor_request_queue
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS  = LIFT_NUM_FLOORS,
  parameter int FLOOR_W     = LIFT_FLOOR_W,
  parameter int DOOR_CYCLES = LIFT_DOOR_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] btn,
  input  logic [FLOOR_W-1:0]    current_floor,
  output logic [NUM_FLOORS-1:0] requests,
  output logic [FLOOR_W-1:0]    max_request,
  output logic [FLOOR_W-1:0]    min_request,
  output logic                  lift_en,
  output logic                  door_open
);

  localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DOOR_CYCLES - 1);

  logic [NUM_FLOORS-1:0] btn_q;
  logic [NUM_FLOORS-1:0] rise;
  logic [NUM_FLOORS-1:0] floor_sel;
  logic [NUM_FLOORS-1:0] req_next;
  logic                  arrive;
  door_state_t           state;
  logic [CNT_W-1:0]      cnt;
`ifdef FLR_REQ_DOOR_REOPEN_EN
  logic                  rise_here;
`endif

  // one-hot decode of the current floor; out-of-range floors select nothing
  always_comb begin
    floor_sel = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (current_floor == FLOOR_W'(f)) floor_sel[f] = 1'b1;
    end
  end

  assign rise    = btn & ~btn_q;
  assign arrive  = |(requests & floor_sel);
  assign lift_en = (state == ST_RUN) & ~arrive;
`ifdef FLR_REQ_DOOR_REOPEN_EN
  assign rise_here = |(rise & floor_sel);
`endif

  // next request vector: latch all rises, but the current floor's bit is
  // cleared when served and presses on it are dropped while the door cycles
  always_comb begin
    req_next = requests | rise;
    if ((state != ST_RUN) || arrive) req_next = req_next & ~floor_sel;
  end

  // button edge-detect history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) btn_q <= '0;
    else          btn_q <= btn;
  end

  // pending request register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) requests <= '0;
    else          requests <= req_next;
  end

  // door sequencing FSM with registered door_open and down-counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      door_open <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (arrive) begin
            state     <= ST_DOOR;
            door_open <= 1'b1;
            cnt       <= CNT_LOAD;
          end
        end
        ST_DOOR: begin
`ifdef FLR_REQ_DOOR_REOPEN_EN
          if (rise_here) begin
            door_open <= 1'b1;
            cnt       <= CNT_LOAD;
          end else
`endif
          if (cnt == '0) begin
            state     <= ST_CLOSE;
            door_open <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_CLOSE: begin
`ifdef FLR_REQ_DOOR_REOPEN_EN
          if (rise_here) begin
            state     <= ST_DOOR;
            door_open <= 1'b1;
            cnt       <= CNT_LOAD;
          end else
`endif
          state <= ST_RUN;
        end
        default: begin
          state     <= ST_RUN;
          door_open <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

  req_extremes #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_extremes (
    .requests      (requests),
    .current_floor (current_floor),
    .max_request   (max_request),
    .min_request   (min_request)
  );

endmodule

// File: tb/tb_floor_request_queue.sv
// Bench for floor_request_queue: timeline-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_floor_request_queue;

  localparam int NF = 8;
  localparam int DC = 4;
`ifdef FLR_REQ_DOOR_REOPEN_EN
  localparam int EXP_TAIL = DC;
`else
  localparam int EXP_TAIL = 1;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NF-1:0] btn;
  logic [2:0]    current_floor;
  logic [NF-1:0] requests;
  logic [2:0]    max_request;
  logic [2:0]    min_request;
  logic          lift_en;
  logic          door_open;

  int total = 0;
  int bad   = 0;

  floor_request_queue dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .btn           (btn),
    .current_floor (current_floor),
    .requests      (requests),
    .max_request   (max_request),
    .min_request   (min_request),
    .lift_en       (lift_en),
    .door_open     (door_open)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: door service as a time window ----------
  bit [NF-1:0] m_req;
  bit [NF-1:0] m_prev;
  int          t;
  int          door_start;

  function automatic bit busy_at(input int x);
    return (x >= door_start) && (x <= door_start + DC);
  endfunction

  function automatic bit door_at(input int x);
    return (x >= door_start) && (x < door_start + DC);
  endfunction

  task automatic m_reset();
    m_req      = '0;
    m_prev     = '0;
    door_start = -100;
  endtask

  task automatic m_step();
    bit [NF-1:0] r;
    bit          was_busy;
    bit          here_ok;
    bit          served;
    int          c;
    c        = int'(current_floor);
    here_ok  = (c < NF);
    r        = btn & ~m_prev;
    was_busy = busy_at(t);
    t++;
    served   = !was_busy && here_ok && m_req[c];
    if (served) begin
      door_start = t;
      m_req[c]   = 1'b0;
    end
`ifdef FLR_REQ_DOOR_REOPEN_EN
    if (was_busy && here_ok && r[c]) door_start = t;
`endif
    for (int f = 0; f < NF; f++) begin
      if (r[f] && !(here_ok && f == c && (was_busy || served))) m_req[f] = 1'b1;
    end
    m_prev = btn;
  endtask

  initial begin
    t = 0;
    m_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) m_reset();
      else          m_step();
    end
  end

  // per-cycle comparison against the model
  initial begin
    int r, emax, emin, c;
    forever begin
      @(negedge clk);
      r = int'(m_req);
      c = int'(current_floor);
      if (r == 0) begin
        emax = c;
        emin = c;
      end else begin
        emax = $clog2(r + 1) - 1;
        emin = $clog2(r & -r);
      end
      chk("m_requests", int'(requests), r);
      chk("m_max", int'(max_request), emax);
      chk("m_min", int'(min_request), emin);
      chk("m_door_open", int'(door_open), int'(door_at(t)));
      chk("m_lift_en", int'(lift_en),
          int'(!busy_at(t) && !((c < NF) && m_req[c])));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, rises;
    bit prev;
    reset_n       = 1'b0;
    btn           = '0;
    current_floor = 3'd0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_requests", int'(requests), 0);
    chk("rst_door", int'(door_open), 0);
    chk("rst_lift_en", int'(lift_en), 1);

    // single request at floor 5, lift walks up from 0
    btn = 8'h20;
    tick();
    btn = '0;
    chk("t2_requests", int'(requests), 'h20);
    chk("t2_max", int'(max_request), 5);
    chk("t2_min", int'(min_request), 5);
    for (int f = 1; f <= 5; f++) begin
      current_floor = 3'(f);
      #1;
      chk("t2_lift_en_walk", int'(lift_en), (f < 5) ? 1 : 0);
      if (f < 5) tick();
    end
    tick();
    chk("t2_door_up", int'(door_open), 1);
    chk("t2_req_cleared", int'(requests), 0);
    n = 0;
    while (door_open && n < 20) begin
      n++;
      tick();
    end
    chk("t2_door_len", n, DC);
    chk("t2_close_lift_en", int'(lift_en), 0);
    tick();
    chk("t2_run_lift_en", int'(lift_en), 1);

    // two simultaneous presses
    current_floor = 3'd4;
    btn = 8'h44;
    tick();
    btn = '0;
    chk("t3_requests", int'(requests), 'h44);
    chk("t3_max", int'(max_request), 6);
    chk("t3_min", int'(min_request), 2);
    chk("t3_lift_en", int'(lift_en), 1);

    // reset with requests pending
    current_floor = 3'd3;
    reset_n = 1'b0;
    #1;
    chk("t1_requests", int'(requests), 0);
    chk("t1_door", int'(door_open), 0);
    chk("t1_lift_en", int'(lift_en), 1);
    chk("t1_max", int'(max_request), 3);
    chk("t1_min", int'(min_request), 3);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // held button latches once
    btn  = 8'h08;
    prev = door_open;
    rises = 0;
    repeat (20) begin
      tick();
      if (door_open && !prev) rises++;
      prev = door_open;
    end
    chk("t4_door_rises", rises, 1);
    chk("t4_no_relatch", int'(requests), 0);
    btn = '0;
    tick();
    btn = 8'h08;
    tick();
    chk("t4_repress", int'(requests), 'h08);
    tick();
    btn = '0;
    chk("t4_repress_door", int'(door_open), 1);
    n = 0;
    while (door_open && n < 20) begin
      n++;
      tick();
    end
    chk("t4_door_len", n, DC);
    repeat (2) tick();

    // press on the open floor late in the door cycle
    current_floor = 3'd2;
    btn = 8'h04;
    tick();
    btn = '0;
    tick();
    chk("t5_door_up", int'(door_open), 1);
    repeat (2) tick();
    btn = 8'h04;
    tick();
    btn = '0;
    n = 0;
    while (door_open && n < 20) begin
      n++;
      tick();
    end
    chk("t5_door_tail", n, EXP_TAIL);
    chk("t5_requests", int'(requests), 0);
    repeat (2) tick();

    // asynchronous reset in the middle of a door cycle
    current_floor = 3'd3;
    btn = 8'h89;
    tick();
    btn = '0;
    tick();
    chk("t6_requests", int'(requests), 'h81);
    chk("t6_door_up", int'(door_open), 1);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_door", int'(door_open), 0);
    chk("t6_async_req", int'(requests), 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("t6_run_lift_en", int'(lift_en), 1);
    chk("t6_door_closed", int'(door_open), 0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
